// File: rtl/rob_if.sv
// Reorder buffer port bundle: issue, CDB writeback, operand query,
// commit and flush signals. master = core side, slave = rob.
interface rob_if;
   logic        issue_sgn;
   logic [5:0]  issue_rd;
   logic        issue_is_store;
   logic [4:0]  rob_new_entry;
   logic        rob_full;
   logic        cdb_valid;
   logic [4:0]  cdb_entry;
   logic [31:0] cdb_result;
   logic        cdb_mispredict;
   logic [31:0] cdb_target_pc;
   logic [4:0]  query_j_entry;
   logic [4:0]  query_k_entry;
   logic        query_j_ready;
   logic        query_k_ready;
   logic [31:0] query_j_value;
   logic [31:0] query_k_value;
   logic        commit_sgn;
   logic [4:0]  rob_entry;
   logic [5:0]  rob_des;
   logic [31:0] rob_result;
   logic        store_commit_sgn;
   logic        flush_sgn;
   logic [31:0] flush_pc;

   modport master (
      output issue_sgn, issue_rd, issue_is_store,
      output cdb_valid, cdb_entry, cdb_result,
      output cdb_mispredict, cdb_target_pc,
      output query_j_entry, query_k_entry,
      input  rob_new_entry, rob_full,
      input  query_j_ready, query_k_ready,
      input  query_j_value, query_k_value,
      input  commit_sgn, rob_entry, rob_des, rob_result,
      input  store_commit_sgn, flush_sgn, flush_pc
   );

   modport slave (
      input  issue_sgn, issue_rd, issue_is_store,
      input  cdb_valid, cdb_entry, cdb_result,
      input  cdb_mispredict, cdb_target_pc,
      input  query_j_entry, query_k_entry,
      output rob_new_entry, rob_full,
      output query_j_ready, query_k_ready,
      output query_j_value, query_k_value,
      output commit_sgn, rob_entry, rob_des, rob_result,
      output store_commit_sgn, flush_sgn, flush_pc
   );
endinterface

// File: rtl/rob.sv
// 16-entry reorder buffer: in-order tag allocation, CDB capture,
// in-order single commit, flush on mispredicted head.
// Ports: clk, rst (sync, active-high), rdy (stall), bus (rob_if.slave).
module rob (
   input logic clk,
   input logic rst,
   input logic rdy,
   rob_if.slave bus
);
   localparam logic [4:0] ENTRY_NULL = 5'd16;
   localparam logic [5:0] NULL_REG   = 6'd32;

   logic [15:0] busy_q, busy_d, ready_q, ready_d;
   logic [15:0] st_q, st_d, mp_q, mp_d;
   logic [5:0]  rd_q  [16];
   logic [5:0]  rd_d  [16];
   logic [31:0] val_q [16];
   logic [31:0] val_d [16];
   logic [31:0] tgt_q [16];
   logic [31:0] tgt_d [16];
   logic [3:0]  head_q, head_d, tail_q, tail_d;
   logic [4:0]  count_q, count_d;
   logic        commit_q, commit_d, store_q, store_d;
   logic        flush_q, flush_d;
   logic [4:0]  entry_q, entry_d;
   logic [5:0]  des_q, des_d;
   logic [31:0] result_q, result_d, fpc_q, fpc_d;

   logic       full, do_commit, do_flush, do_issue, cdb_hit;
   logic [3:0] cdb_idx, j_idx, k_idx;
   logic       j_match, k_match;

   assign full      = (count_q == 5'd16);
   assign do_commit = busy_q[head_q] & ready_q[head_q];
   assign do_flush  = do_commit & mp_q[head_q];
   // A full buffer can still take an issue into the slot freed by
   // the commit happening on the same edge.
   assign do_issue  = bus.issue_sgn & (~full | do_commit);
   assign cdb_idx   = bus.cdb_entry[3:0];
   assign cdb_hit   = bus.cdb_valid & ~bus.cdb_entry[4] & busy_q[cdb_idx];

   always_comb begin
      busy_d   = busy_q;
      ready_d  = ready_q;
      st_d     = st_q;
      mp_d     = mp_q;
      rd_d     = rd_q;
      val_d    = val_q;
      tgt_d    = tgt_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      commit_d = commit_q;
      store_d  = store_q;
      flush_d  = flush_q;
      entry_d  = entry_q;
      des_d    = des_q;
      result_d = result_q;
      fpc_d    = fpc_q;
      if (rdy) begin
         commit_d = do_commit;
         store_d  = do_commit & st_q[head_q];
         flush_d  = do_flush;
         if (do_commit) begin
            entry_d  = {1'b0, head_q};
            des_d    = st_q[head_q] ? NULL_REG : rd_q[head_q];
            result_d = val_q[head_q];
         end
         if (do_flush) begin
            fpc_d   = tgt_q[head_q];
            busy_d  = '0;
            ready_d = '0;
            st_d    = '0;
            mp_d    = '0;
            for (int i = 0; i < 16; i++) begin
               rd_d[i]  = NULL_REG;
               val_d[i] = '0;
               tgt_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (cdb_hit) begin
               ready_d[cdb_idx] = 1'b1;
               mp_d[cdb_idx]    = bus.cdb_mispredict;
               val_d[cdb_idx]   = bus.cdb_result;
               tgt_d[cdb_idx]   = bus.cdb_target_pc;
            end
            if (do_commit) begin
               busy_d[head_q]  = 1'b0;
               ready_d[head_q] = 1'b0;
               st_d[head_q]    = 1'b0;
               mp_d[head_q]    = 1'b0;
               rd_d[head_q]    = NULL_REG;
               val_d[head_q]   = '0;
               tgt_d[head_q]   = '0;
               head_d          = head_q + 4'd1;
            end
            if (do_issue) begin
               busy_d[tail_q]  = 1'b1;
               ready_d[tail_q] = 1'b0;
               st_d[tail_q]    = bus.issue_is_store;
               mp_d[tail_q]    = 1'b0;
               rd_d[tail_q]    = bus.issue_rd;
               tail_d          = tail_q + 4'd1;
            end
            count_d = count_q + {4'd0, do_issue}
                    - {4'd0, do_commit};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         ready_q <= '0;
         st_q    <= '0;
         mp_q    <= '0;
         for (int i = 0; i < 16; i++) begin
            rd_q[i]  <= NULL_REG;
            val_q[i] <= '0;
            tgt_q[i] <= '0;
         end
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         commit_q <= 1'b0;
         store_q  <= 1'b0;
         flush_q  <= 1'b0;
         entry_q  <= ENTRY_NULL;
         des_q    <= NULL_REG;
         result_q <= '0;
         fpc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         st_q     <= st_d;
         mp_q     <= mp_d;
         rd_q     <= rd_d;
         val_q    <= val_d;
         tgt_q    <= tgt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         commit_q <= commit_d;
         store_q  <= store_d;
         flush_q  <= flush_d;
         entry_q  <= entry_d;
         des_q    <= des_d;
         result_q <= result_d;
         fpc_q    <= fpc_d;
      end
   end

   // Operand query with same-cycle CDB bypass for pending entries.
   assign j_idx   = bus.query_j_entry[3:0];
   assign k_idx   = bus.query_k_entry[3:0];
   assign j_match = bus.cdb_valid & (bus.cdb_entry == bus.query_j_entry);
   assign k_match = bus.cdb_valid & (bus.cdb_entry == bus.query_k_entry);

   assign bus.query_j_ready = ~bus.query_j_entry[4] & busy_q[j_idx]
                            & (ready_q[j_idx] | j_match);
   assign bus.query_k_ready = ~bus.query_k_entry[4] & busy_q[k_idx]
                            & (ready_q[k_idx] | k_match);
   assign bus.query_j_value =
      bus.query_j_entry[4] ? 32'd0 :
      (busy_q[j_idx] & ~ready_q[j_idx] & j_match) ? bus.cdb_result :
      val_q[j_idx];
   assign bus.query_k_value =
      bus.query_k_entry[4] ? 32'd0 :
      (busy_q[k_idx] & ~ready_q[k_idx] & k_match) ? bus.cdb_result :
      val_q[k_idx];

   assign bus.rob_new_entry    = {1'b0, tail_q};
   assign bus.rob_full         = full;
   assign bus.commit_sgn       = commit_q;
   assign bus.rob_entry        = entry_q;
   assign bus.rob_des          = des_q;
   assign bus.rob_result       = result_q;
   assign bus.store_commit_sgn = store_q;
   assign bus.flush_sgn        = flush_q;
   assign bus.flush_pc         = fpc_q;
endmodule

// File: tb/tb_rob.sv
// Testbench for rob: table vectors, directed corner sequences and
// random traffic checked against a queue-based program-order model.
module tb_rob;
   logic clk = 1'b0;
   logic rst;
   logic rdy;
   rob_if bus ();

   rob dut (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: live tags in program order, plus per-tag contents.
   int          order[$];
   int          m_tail;
   bit          m_busy[16];
   bit          m_rdy[16];
   bit          m_st[16];
   bit          m_mp[16];
   logic [5:0]  m_rd[16];
   logic [31:0] m_val[16];
   logic [31:0] m_tgt[16];
   bit          e_commit, e_store, e_flush;
   logic [4:0]  e_entry;
   logic [5:0]  e_des;
   logic [31:0] e_result, e_fpc;

   task automatic clear_tag(int t);
      m_busy[t] = 0;
      m_rdy[t]  = 0;
      m_st[t]   = 0;
      m_mp[t]   = 0;
      m_rd[t]   = 6'd32;
      m_val[t]  = 0;
      m_tgt[t]  = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) clear_tag(i);
      order.delete();
      m_tail   = 0;
      e_commit = 0;
      e_store  = 0;
      e_flush  = 0;
      e_entry  = 5'd16;
      e_des    = 6'd32;
      e_result = 0;
      e_fpc    = 0;
   endtask

   task automatic model_edge();
      bit com;
      bit full0;
      int h;
      int c;
      if (rst) begin
         model_reset();
         return;
      end
      if (!rdy) return;
      full0 = (order.size() == 16);
      com   = (order.size() > 0) && m_rdy[order[0]];
      h     = com ? order[0] : 0;
      e_commit = com;
      e_store  = com && m_st[h];
      e_flush  = com && m_mp[h];
      if (com) begin
         e_entry  = h[4:0];
         e_des    = m_st[h] ? 6'd32 : m_rd[h];
         e_result = m_val[h];
      end
      if (e_flush) begin
         e_fpc = m_tgt[h];
         for (int i = 0; i < 16; i++) clear_tag(i);
         order.delete();
         m_tail = 0;
         return;
      end
      c = int'(bus.cdb_entry);
      if (bus.cdb_valid && c < 16 && m_busy[c]) begin
         m_rdy[c] = 1;
         m_mp[c]  = bus.cdb_mispredict;
         m_val[c] = bus.cdb_result;
         m_tgt[c] = bus.cdb_target_pc;
      end
      if (com) begin
         void'(order.pop_front());
         clear_tag(h);
      end
      if (bus.issue_sgn && (!full0 || com)) begin
         m_busy[m_tail] = 1;
         m_rdy[m_tail]  = 0;
         m_st[m_tail]   = bus.issue_is_store;
         m_mp[m_tail]   = 0;
         m_rd[m_tail]   = bus.issue_rd;
         order.push_back(m_tail);
         m_tail = (m_tail + 1) % 16;
      end
   endtask

   function automatic bit q_rdy(logic [4:0] t);
      if (t >= 16) return 0;
      return m_busy[t] && (m_rdy[t] ||
             (bus.cdb_valid && bus.cdb_entry == t));
   endfunction

   function automatic logic [31:0] q_val(logic [4:0] t);
      if (t >= 16) return 0;
      if (m_busy[t] && !m_rdy[t] && bus.cdb_valid && bus.cdb_entry == t)
         return bus.cdb_result;
      return m_val[t];
   endfunction

   task automatic check_comb();
      chk("new_entry", bus.rob_new_entry, m_tail);
      chk("full", bus.rob_full, order.size() == 16);
      chk("qj_ready", bus.query_j_ready, q_rdy(bus.query_j_entry));
      chk("qk_ready", bus.query_k_ready, q_rdy(bus.query_k_entry));
      chk("qj_value", bus.query_j_value, q_val(bus.query_j_entry));
      chk("qk_value", bus.query_k_value, q_val(bus.query_k_entry));
   endtask

   task automatic check_regs();
      chk("commit", bus.commit_sgn, e_commit);
      chk("store", bus.store_commit_sgn, e_store);
      chk("flush", bus.flush_sgn, e_flush);
      chk("rob_entry", bus.rob_entry, e_entry);
      chk("rob_des", bus.rob_des, e_des);
      chk("rob_result", bus.rob_result, e_result);
      chk("flush_pc", bus.flush_pc, e_fpc);
   endtask

   // Called one time unit after a rising edge.
   task automatic tick();
      #7;
      check_comb();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic drive(bit iss, logic [5:0] rd, bit st, bit cv,
                        logic [4:0] ce, logic [31:0] cr, bit mp,
                        logic [31:0] tgt);
      bus.issue_sgn      = iss;
      bus.issue_rd       = rd;
      bus.issue_is_store = st;
      bus.cdb_valid      = cv;
      bus.cdb_entry      = ce;
      bus.cdb_result     = cr;
      bus.cdb_mispredict = mp;
      bus.cdb_target_pc  = tgt;
   endtask

   task automatic idle();
      drive(0, 6'd0, 0, 0, 5'd16, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1;
      rdy = 1;
      idle();
      bus.query_j_entry = 5'd16;
      bus.query_k_entry = 5'd16;
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
      rst = 0;
   endtask

   typedef struct {
      bit          iss;
      logic [5:0]  rd;
      bit          cv;
      logic [4:0]  ce;
      logic [31:0] cr;
      bit          c;
      logic [4:0]  ent;
      logic [5:0]  des;
      logic [31:0] res;
      logic [4:0]  ne;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int pulses;
      int cand[$];
      logic [4:0] t;

      tbl[0]  = '{1, 6'd5, 0, 5'd16, 32'h0,    0, 5'd0, 6'd0, 32'h0,    5'd1};
      tbl[1]  = '{0, 6'd0, 1, 5'd0,  32'h1234, 0, 5'd0, 6'd0, 32'h0,    5'd1};
      tbl[2]  = '{0, 6'd0, 0, 5'd16, 32'h0,    1, 5'd0, 6'd5, 32'h1234, 5'd1};
      tbl[3]  = '{0, 6'd0, 0, 5'd16, 32'h0,    0, 5'd0, 6'd0, 32'h0,    5'd1};
      tbl[4]  = '{1, 6'd1, 0, 5'd16, 32'h0,    0, 5'd0, 6'd0, 32'h0,    5'd2};
      tbl[5]  = '{1, 6'd2, 0, 5'd16, 32'h0,    0, 5'd0, 6'd0, 32'h0,    5'd3};
      tbl[6]  = '{1, 6'd3, 0, 5'd16, 32'h0,    0, 5'd0, 6'd0, 32'h0,    5'd4};
      tbl[7]  = '{0, 6'd0, 1, 5'd3,  32'h33,   0, 5'd0, 6'd0, 32'h0,    5'd4};
      tbl[8]  = '{0, 6'd0, 1, 5'd2,  32'h22,   0, 5'd0, 6'd0, 32'h0,    5'd4};
      tbl[9]  = '{0, 6'd0, 1, 5'd1,  32'h11,   0, 5'd0, 6'd0, 32'h0,    5'd4};
      tbl[10] = '{0, 6'd0, 0, 5'd16, 32'h0,    1, 5'd1, 6'd1, 32'h11,   5'd4};
      tbl[11] = '{0, 6'd0, 0, 5'd16, 32'h0,    1, 5'd2, 6'd2, 32'h22,   5'd4};
      tbl[12] = '{0, 6'd0, 0, 5'd16, 32'h0,    1, 5'd3, 6'd3, 32'h33,   5'd4};
      tbl[13] = '{0, 6'd0, 0, 5'd16, 32'h0,    0, 5'd0, 6'd0, 32'h0,    5'd4};

      do_reset();
      chk("rst_commit", bus.commit_sgn, 0);
      chk("rst_entry", bus.rob_entry, 5'd16);
      chk("rst_des", bus.rob_des, 6'd32);
      chk("rst_new_entry", bus.rob_new_entry, 0);
      chk("rst_full", bus.rob_full, 0);

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].iss, tbl[i].rd, 0, tbl[i].cv, tbl[i].ce,
               tbl[i].cr, 0, 0);
         tick();
         chk("tbl_commit", bus.commit_sgn, tbl[i].c);
         if (tbl[i].c) begin
            chk("tbl_entry", bus.rob_entry, tbl[i].ent);
            chk("tbl_des", bus.rob_des, tbl[i].des);
            chk("tbl_result", bus.rob_result, tbl[i].res);
         end
         chk("tbl_new_entry", bus.rob_new_entry, tbl[i].ne);
      end

      // Fill, overflow attempt, wrap, commit+issue while full.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, 6'(i + 1), 0, 0, 5'd16, 0, 0, 0);
         tick();
      end
      chk("fill_full", bus.rob_full, 1);
      drive(1, 6'd20, 0, 0, 5'd16, 0, 0, 0);
      tick();
      chk("ovf_full", bus.rob_full, 1);
      chk("ovf_new_entry", bus.rob_new_entry, 0);
      drive(0, 6'd0, 0, 1, 5'd0, 32'hA0, 0, 0);
      tick();
      idle();
      tick();
      chk("wrap_commit", bus.commit_sgn, 1);
      chk("wrap_des", bus.rob_des, 6'd1);
      chk("wrap_not_full", bus.rob_full, 0);
      chk("wrap_tag", bus.rob_new_entry, 0);
      drive(1, 6'd7, 0, 0, 5'd16, 0, 0, 0);
      tick();
      chk("wrap_full", bus.rob_full, 1);
      chk("wrap_tail", bus.rob_new_entry, 1);
      drive(0, 6'd0, 0, 1, 5'd1, 32'hA1, 0, 0);
      tick();
      drive(1, 6'd8, 0, 0, 5'd16, 0, 0, 0);
      tick();
      chk("ci_commit", bus.commit_sgn, 1);
      chk("ci_entry", bus.rob_entry, 1);
      chk("ci_full", bus.rob_full, 1);
      chk("ci_tail", bus.rob_new_entry, 2);

      // Mispredict at head flushes; same-edge issue/CDB discarded.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 6'(i + 10), 0, 0, 5'd16, 0, 0, 0);
         tick();
      end
      drive(0, 6'd0, 0, 1, 5'd0, 32'h44, 1, 32'h100);
      tick();
      drive(1, 6'd9, 0, 1, 5'd1, 32'h55, 0, 0);
      tick();
      chk("mp_commit", bus.commit_sgn, 1);
      chk("mp_flush", bus.flush_sgn, 1);
      chk("mp_pc", bus.flush_pc, 32'h100);
      chk("mp_des", bus.rob_des, 6'd10);
      chk("mp_tag", bus.rob_new_entry, 0);
      drive(0, 6'd0, 0, 1, 5'd1, 32'h66, 0, 0);
      tick();
      chk("mp_flush_drop", bus.flush_sgn, 0);
      idle();
      tick();
      chk("mp_no_commit", bus.commit_sgn, 0);

      // Query bypass.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 6'(i + 1), 0, 0, 5'd16, 0, 0, 0);
         tick();
      end
      drive(0, 6'd0, 0, 1, 5'd3, 32'd7, 0, 0);
      bus.query_j_entry = 5'd3;
      bus.query_k_entry = 5'd16;
      #1;
      chk("byp_ready", bus.query_j_ready, 1);
      chk("byp_value", bus.query_j_value, 7);
      chk("null_ready", bus.query_k_ready, 0);
      chk("null_value", bus.query_k_value, 0);
      tick();
      idle();
      #1;
      chk("stored_ready", bus.query_j_ready, 1);
      chk("stored_value", bus.query_j_value, 7);
      tick();

      // Pause across a pending store commit.
      do_reset();
      drive(1, 6'd32, 1, 0, 5'd16, 0, 0, 0);
      tick();
      drive(0, 6'd0, 0, 1, 5'd0, 32'hABC, 0, 0);
      tick();
      idle();
      rdy = 0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_hold", bus.commit_sgn, 0);
      end
      rdy = 1;
      tick();
      pulses += int'(bus.commit_sgn);
      chk("st_commit", bus.store_commit_sgn, 1);
      chk("st_des", bus.rob_des, 6'd32);
      chk("st_result", bus.rob_result, 32'hABC);
      rdy = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pulse_hold", bus.commit_sgn, 1);
      end
      rdy = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         pulses += int'(bus.commit_sgn);
      end
      chk("one_pulse", pulses, 1);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         rdy = ($urandom_range(0, 9) != 0);
         bus.issue_sgn      = $urandom_range(0, 1);
         bus.issue_rd       = 6'($urandom_range(0, 32));
         bus.issue_is_store = ($urandom_range(0, 3) == 0);
         bus.cdb_valid      = 0;
         bus.cdb_entry      = 5'd16;
         bus.cdb_result     = $urandom;
         bus.cdb_mispredict = ($urandom_range(0, 15) == 0);
         bus.cdb_target_pc  = $urandom;
         cand.delete();
         foreach (order[i])
            if (!m_rdy[order[i]]) cand.push_back(order[i]);
         if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
            bus.cdb_valid = 1;
            bus.cdb_entry = 5'(cand[$urandom_range(0, cand.size() - 1)]);
         end else if ($urandom_range(0, 9) == 0) begin
            t = 5'($urandom_range(0, 16));
            if (t == 16 || !m_busy[t]) begin
               bus.cdb_valid = 1;
               bus.cdb_entry = t;
            end
         end
         bus.query_j_entry = 5'($urandom_range(0, 16));
         bus.query_k_entry = 5'($urandom_range(0, 16));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
